id_scoreboard: RTL and testbench

- Register-hazard scoreboard and issue controller for the ID stage of the 5-stage LoongArch pipeline (IF/ID/EX/MEM/WB).
- Tracks, per architectural register, how many issued-but-unretired instructions will write it.
- Drives the ID stall (ID ready_go = ~id_stall) when an operand or destination conflicts with in-flight writers.
- No forwarding: a consumer waits until its producer has been written back.

---
 rtl/id_scoreboard.sv | 93 +++++++++
 tb/tb_id_scoreboard.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// ID-stage register-hazard scoreboard: tracks in-flight writers per GPR and
// stalls ID on RAW hazards or when a destination has no free writer slot.
module id_scoreboard #(
  parameter int unsigned NREG         = 32,
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned CNT_W        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rj,
  input  logic        id_rj_used,
  input  logic [4:0]  id_rk,
  input  logic        id_rk_used,
  input  logic [4:0]  id_dest,
  input  logic        id_gr_we,
  input  logic        id_fire,
  input  logic        wb_valid,
  input  logic [4:0]  wb_dest,
  input  logic        wb_gr_we,
  input  logic        flush,
  output logic        id_stall,
  output logic        rj_pending,
  output logic        rk_pending,
  output logic [31:0] stall_cycles
);

  localparam int unsigned RW = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [31:0] SC_MAX = 32'hFFFF_FFFF;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [31:0]      stall_cycles_q, stall_cycles_d;
  logic             inc, dec, dest_full;

  // Hazard query against registered counts; a same-cycle WB retire does not clear it.
  always_comb begin
    rj_pending = id_rj_used && (id_rj != '0) && (cnt_q[id_rj] != '0);
    rk_pending = id_rk_used && (id_rk != '0) && (cnt_q[id_rk] != '0);
    dest_full  = id_gr_we && (id_dest != '0) && (cnt_q[id_dest] == CNT_MAX);
    id_stall   = id_valid && (rj_pending || rk_pending || dest_full);
    inc        = id_fire && id_gr_we && (id_dest != '0);
    dec        = wb_valid && wb_gr_we && (wb_dest != '0);
  end

  // Per-register next count; issue and retire to the same register cancel.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (r != 0) begin
        if (inc && (id_dest == RW'(r)) && !(dec && (wb_dest == RW'(r)))) begin
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
        end else if (dec && (wb_dest == RW'(r)) && !(inc && (id_dest == RW'(r)))) begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (id_valid && id_stall && (stall_cycles_q != SC_MAX)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

  // Protocol checks on the surrounding pipeline.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(id_fire && id_stall));
      if (!flush) begin
        assert (!(dec && (cnt_q[wb_dest] == '0)));
        assert (!(inc && (cnt_q[id_dest] == CNT_MAX)));
      end
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed hazard scenarios plus random traffic,
// checked against a model that keeps the list of in-flight destinations.
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rj = '0;
  logic        id_rj_used = 1'b0;
  logic [4:0]  id_rk = '0;
  logic        id_rk_used = 1'b0;
  logic [4:0]  id_dest = '0;
  logic        id_gr_we = 1'b0;
  logic        id_fire = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_dest = '0;
  logic        wb_gr_we = 1'b0;
  logic        flush = 1'b0;
  logic        id_stall;
  logic        rj_pending;
  logic        rk_pending;
  logic [31:0] stall_cycles;

  id_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rj(id_rj),
    .id_rj_used(id_rj_used), .id_rk(id_rk), .id_rk_used(id_rk_used),
    .id_dest(id_dest), .id_gr_we(id_gr_we), .id_fire(id_fire),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_gr_we(wb_gr_we),
    .flush(flush), .id_stall(id_stall), .rj_pending(rj_pending),
    .rk_pending(rk_pending), .stall_cycles(stall_cycles)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [4:0] rj;
    logic       rju;
    logic [4:0] rk;
    logic       rku;
    logic [4:0] dest;
    logic       we;
    logic       fire;
    logic       wbv;
    logic [4:0] wbd;
    logic       fl;
  } stim_t;

  typedef struct {
    bit          skip;
    logic        stall;
    logic        rjp;
    logic        rkp;
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   inflight[$];   // destinations issued but not yet written back
  longint unsigned sc_model = 0;
  int   total = 0;
  int   bad = 0;

  function automatic int pend(input int r);
    int n = 0;
    foreach (inflight[i]) if (inflight[i] == r) n++;
    return n;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // One cycle of stimulus: expectation from the model, then model advance.
  task automatic step(input stim_t s);
    exp_t e;
    logic fire_eff, wb_eff, df;
    @(posedge clk); #1;
    e.skip  = s.rst;
    e.rjp   = s.rju && (s.rj != 0) && (pend(int'(s.rj)) > 0);
    e.rkp   = s.rku && (s.rk != 0) && (pend(int'(s.rk)) > 0);
    df      = s.we && (s.dest != 0) && (pend(int'(s.dest)) == 3);
    e.stall = s.v && (e.rjp || e.rkp || df);
    e.sc    = 32'(sc_model);
    fire_eff = s.fire && s.v && !e.stall && !s.rst;
    wb_eff   = s.wbv && !((s.wbd != 0) && (pend(int'(s.wbd)) == 0));
    reset = s.rst; id_valid = s.v; id_rj = s.rj; id_rj_used = s.rju;
    id_rk = s.rk; id_rk_used = s.rku; id_dest = s.dest; id_gr_we = s.we;
    id_fire = fire_eff; wb_valid = wb_eff; wb_dest = s.wbd; wb_gr_we = wb_eff;
    flush = s.fl;
    exp_q.push_back(e);
    if (s.rst) begin
      inflight.delete();
      sc_model = 0;
    end else begin
      if (e.stall && sc_model != 64'hFFFF_FFFF) sc_model++;
      if (s.fl) begin
        inflight.delete();
      end else begin
        if (wb_eff && s.wbd != 0) begin
          foreach (inflight[i]) if (inflight[i] == int'(s.wbd)) begin
            inflight.delete(i);
            break;
          end
        end
        if (fire_eff && s.we && s.dest != 0) inflight.push_back(int'(s.dest));
      end
    end
  endtask

  task automatic drain();
    stim_t s;
    while (inflight.size() > 0) begin
      s = idle();
      s.wbv = 1'b1;
      s.wbd = 5'(inflight[0]);
      step(s);
    end
  endtask

  // Monitor: outputs are stable mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!e.skip) begin
        chk("id_stall", 32'(id_stall), 32'(e.stall));
        chk("rj_pending", 32'(rj_pending), 32'(e.rjp));
        chk("rk_pending", 32'(rk_pending), 32'(e.rkp));
        chk("stall_cycles", stall_cycles, e.sc);
      end
    end
  end

  initial begin
    stim_t s, rd;
    s = idle(); s.rst = 1'b1;
    step(s);
    step(idle());

    // Back-to-back dependence on r5; WB retire in the third stalled cycle.
    s = idle(); s.v = 1; s.dest = 5; s.we = 1; s.fire = 1;
    step(s);
    rd = idle(); rd.v = 1; rd.rj = 5; rd.rju = 1; rd.dest = 6; rd.we = 1; rd.fire = 1;
    step(rd); step(rd);
    s = rd; s.wbv = 1; s.wbd = 5;
    step(s);
    step(rd);
    drain();

    // r0 is never tracked.
    s = idle(); s.v = 1; s.dest = 0; s.we = 1; s.fire = 1;
    step(s);
    s = idle(); s.v = 1; s.rj = 0; s.rju = 1; s.rk = 0; s.rku = 1; s.fire = 1;
    step(s); step(s);

    // Simultaneous issue and retire on r7.
    s = idle(); s.v = 1; s.dest = 7; s.we = 1; s.fire = 1;
    step(s);
    s.wbv = 1; s.wbd = 7;
    step(s);
    rd = idle(); rd.v = 1; rd.rk = 7; rd.rku = 1;
    step(rd);
    drain();

    // Destination saturation on r9.
    s = idle(); s.v = 1; s.dest = 9; s.we = 1; s.fire = 1;
    step(s); step(s); step(s);
    step(s);
    rd = s; rd.wbv = 1; rd.wbd = 9;
    step(rd);
    step(s);
    drain();

    // Flush with a concurrent retire.
    s = idle(); s.v = 1; s.dest = 3; s.we = 1; s.fire = 1;
    step(s); step(s);
    s.dest = 4;
    step(s);
    rd = idle(); rd.v = 1; rd.rj = 3; rd.rju = 1; rd.rk = 4; rd.rku = 1;
    s = rd; s.fl = 1; s.wbv = 1; s.wbd = 3;
    step(s);
    step(rd); step(rd);

    // Reset in the middle of a stall.
    s = idle(); s.v = 1; s.dest = 10; s.we = 1; s.fire = 1;
    step(s);
    rd = idle(); rd.v = 1; rd.rj = 10; rd.rju = 1;
    step(rd); step(rd);
    s = rd; s.rst = 1;
    step(s);
    step(rd); step(rd);

    // Random legal traffic on a small register window.
    for (int i = 0; i < 400; i++) begin
      s = idle();
      s.v    = 1'($urandom_range(0, 3) != 0);
      s.rj   = 5'($urandom_range(0, 7));
      s.rju  = 1'($urandom);
      s.rk   = 5'($urandom_range(0, 7));
      s.rku  = 1'($urandom);
      s.dest = 5'($urandom_range(0, 7));
      s.we   = 1'($urandom);
      s.fire = 1'($urandom_range(0, 3) != 0);
      if (inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
        s.wbv = 1'b1;
        s.wbd = 5'(inflight[$urandom_range(0, inflight.size() - 1)]);
      end
      s.fl = 1'($urandom_range(0, 60) == 0);
      step(s);
    end
    drain();
    step(idle());

    @(posedge clk); @(negedge clk); #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
